// File: rtl/seq_divider_if.sv
// Request/response bundle between the control unit and the iterative divider.
// The control unit drives the operands and start; the divider returns busy, valid and the result.
interface seq_divider_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring iterative divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved in a single cycle.
module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  seq_divider_if.slave div_if
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_REM = 2'b10;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              signed_op, is_rem, div_zero, overflow;
  logic [XLEN:0]     rem_sh;
  logic signed [XLEN:0] trial;
  logic [XLEN-1:0]   rem_step, quo_step;

  function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? neg2(v) : v;
  endfunction

  // Quotient/remainder were computed on magnitudes; restore the RISC-V sign rules here.
  function automatic logic [XLEN-1:0] fixup(input logic [1:0] op, input logic sa, input logic sb,
                                            input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
    if (op[1]) return (op == OP_REM && sa) ? neg2(r) : r;
    return (op == OP_DIV && (sa ^ sb)) ? neg2(q) : q;
  endfunction

  assign signed_op = ~div_if.op_i[0];
  assign is_rem    = div_if.op_i[1];
  assign div_zero  = (div_if.b_i == '0);
  assign overflow  = signed_op && (div_if.a_i == INT_MIN) && (div_if.b_i == '1);

  // Before the last step the partial remainder is below 2^(XLEN-1), so no bit is lost.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[XLEN-1]};
    trial    = $signed(rem_sh - {1'b0, dvs_q});
    rem_step = (trial >= 0) ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ~trial[XLEN]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (div_if.start_i) begin
          op_d     = div_if.op_i;
          sign_a_d = signed_op & div_if.a_i[XLEN-1];
          sign_b_d = signed_op & div_if.b_i[XLEN-1];
          dvd_d    = abs_val(div_if.a_i, signed_op);
          dvs_d    = abs_val(div_if.b_i, signed_op);
          rem_d    = '0;
          quo_d    = '0;
          cnt_d    = '0;
          if (div_zero) begin
            result_d = is_rem ? div_if.a_i : '1;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = is_rem ? '0 : INT_MIN;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[XLEN-2:0], 1'b0};
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) begin
          result_d = fixup(op_q, sign_a_q, sign_b_q, quo_step, rem_step);
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign div_if.busy_o   = (state_q != IDLE);
  assign div_if.valid_o  = (state_q == DONE);
  assign div_if.result_o = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: expected results are queued at issue time and
// popped when valid_o fires, with latency, pulse width and reset abort checked alongside.
module tb_seq_divider;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic clk;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  seq_divider_if #(.XLEN(32)) dif ();

  seq_divider #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .div_if (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      DIV:     return 32'($signed(a) / $signed(b));
      REM:     return 32'($signed(a) % $signed(b));
      DIVU:    return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drives one start pulse (edge E0), then scrambles the operand inputs.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit expect_out);
    @(negedge clk);
    dif.start_i = 1'b1;
    dif.op_i    = op;
    dif.a_i     = a;
    dif.b_i     = b;
    if (expect_out) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
    end
    @(posedge clk);
    #1;
    dif.start_i = 1'b0;
    dif.op_i    = 2'($urandom_range(0, 3));
    dif.a_i     = $urandom;
    dif.b_i     = $urandom;
  endtask

  // Waits for valid_o, counting edges from E0; optionally pulses start at cycle inj.
  task automatic collect(input string tag, input int inj, input bit check_drop);
    int lat = 1;
    bit got = 1'b0;
    logic [31:0] res;
    logic [31:0] e;
    int el;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lat == inj) begin
        dif.start_i = 1'b1;
        dif.op_i    = REM;
        dif.a_i     = 32'd5;
        dif.b_i     = 32'd2;
      end else begin
        dif.start_i = 1'b0;
      end
      if (dif.valid_o) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    chk({tag, " got_valid"}, 32'(got), 32'd1);
    if (got && exp_q.size() > 0) begin
      res = dif.result_o;
      e   = exp_q.pop_front();
      el  = lat_q.pop_front();
      chk({tag, " result"}, res, e);
      chk({tag, " latency"}, 32'(lat), 32'(el));
      chk({tag, " busy_in_done"}, 32'(dif.busy_o), 32'd1);
      if (check_drop) begin
        @(posedge clk);
        #1;
        dif.start_i = 1'b0;
        @(negedge clk);
        chk({tag, " valid_drop"}, 32'(dif.valid_o), 32'd0);
        chk({tag, " busy_drop"}, 32'(dif.busy_o), 32'd0);
        chk({tag, " result_hold"}, dif.result_o, e);
      end
    end
    dif.start_i = 1'b0;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          seen_valid;

    rst_n       = 1'b0;
    dif.start_i = 1'b0;
    dif.op_i    = 2'b00;
    dif.a_i     = '0;
    dif.b_i     = '0;
    #12;
    chk("reset busy", 32'(dif.busy_o), 32'd0);
    chk("reset valid", 32'(dif.valid_o), 32'd0);
    chk("reset result", dif.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    collect("divu_100_7", 33, 1'b1);
    issue(REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    collect("remu_100_7", 0, 1'b0);
    issue(DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b1);
    collect("div_m100_7", 0, 1'b0);
    issue(REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b1);
    collect("rem_m100_7", 0, 1'b1);

    issue(DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    collect("div_by0", 0, 1'b1);
    issue(DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    collect("divu_by0", 0, 1'b0);
    issue(REM, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 1'b1);
    collect("rem_by0", 0, 1'b0);

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    collect("div_ovf", 0, 1'b0);
    issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b1);
    collect("rem_ovf", 0, 1'b0);
    issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 1'b1);
    collect("divu_ovf_ops", 0, 1'b0);
    issue(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b1);
    collect("remu_ovf_ops", 0, 1'b0);

    issue(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
    collect("start_while_busy", 10, 1'b0);
    issue(DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b1);
    collect("back_to_back", 0, 1'b1);

    for (int k = 0; k < 4; k++) begin
      rop = 2'(k);
      ra  = $urandom;
      rb  = (k < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (k == 1) rb = -rb;
      issue(rop, ra, rb, ref_res(rop, ra, rb), ref_lat(rop, ra, rb), 1'b1);
      collect($sformatf("rand%0d", k), 0, 1'b0);
    end

    issue(DIVU, 32'd1000, 32'd3, 32'd0, 33, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("abort busy_before", 32'(dif.busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(dif.busy_o), 32'd0);
    chk("abort valid", 32'(dif.valid_o), 32'd0);
    chk("abort result", dif.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_valid |= dif.valid_o;
    end
    chk("abort no_valid", 32'(seen_valid), 32'd0);
    issue(DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1);
    collect("after_abort", 0, 1'b1);

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
